// File: rtl/conv1d_cfu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv1d_cfu_sequencer                                                        |
// | Drives the conv1d CFU command port to produce one output point unaided.     |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module conv1d_cfu_sequencer #(
  parameter int         INT32_SIZE = 32,
  parameter int         BYTE_SIZE  = 8,
  parameter logic [6:0] NOP_CMD    = 7'd19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_start,
  input  logic [INT32_SIZE-1:0] job_start_x,
  input  logic                  job_write_x,
  input  logic [15:0]           job_filter_bytes,
  input  logic [15:0]           job_input_bytes,
  input  logic [INT32_SIZE-1:0] job_input_base,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_SIZE-1:0]  in_data,
  output logic                  cfu_en,
  output logic [6:0]            cfu_cmd,
  output logic [INT32_SIZE-1:0] cfu_inp0,
  output logic [INT32_SIZE-1:0] cfu_inp1,
  input  logic [INT32_SIZE-1:0] cfu_ret,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [INT32_SIZE-1:0] res_data
);

  localparam logic [6:0] c_cmd_input  = 7'd1;
  localparam logic [6:0] c_cmd_filter = 7'd2;
  localparam logic [6:0] c_cmd_start  = 7'd6;
  localparam logic [6:0] c_cmd_result = 7'd7;
  localparam logic [6:0] c_cmd_set_x  = 7'd8;
  localparam logic [6:0] c_cmd_poll   = 7'd9;

  typedef enum logic [3:0] {
    S_IDLE, S_SET_X, S_LOAD_F, S_LOAD_I, S_START, S_POLL, S_FETCH, S_CAPTURE, S_OUTPUT
  } state_t;

  state_t                r_state, w_next;
  logic [15:0]           r_fcnt, r_icnt;
  logic [INT32_SIZE-1:0] r_base, r_addr, r_pack;
  logic [1:0]            r_pcnt;
  logic                  r_poll_flag;
  logic                  r_cfu_en, r_res_valid;
  logic [6:0]            r_cmd;
  logic [INT32_SIZE-1:0] r_inp0, r_inp1, r_res_data;

  logic                  w_accept, w_fire;
  logic [INT32_SIZE-1:0] w_word;
  logic [6:0]            w_cmd;
  logic [INT32_SIZE-1:0] w_inp0, w_inp1;

  assign in_ready  = ((r_state == S_LOAD_F) && (r_fcnt != 16'd0)) ||
                     ((r_state == S_LOAD_I) && (r_icnt != 16'd0));
  assign busy      = (r_state != S_IDLE);
  assign cfu_en    = r_cfu_en;
  assign cfu_cmd   = r_cmd;
  assign cfu_inp0  = r_inp0;
  assign cfu_inp1  = r_inp1;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  assign w_accept = in_valid && in_ready;
  assign w_fire   = w_accept && (r_pcnt == 2'd3);
  assign w_word   = {in_data, r_pack[INT32_SIZE-BYTE_SIZE-1:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Commands are registered on the transition so each state presents its own command.
  always_comb begin
    w_next = r_state;
    w_cmd  = NOP_CMD;
    w_inp0 = '0;
    w_inp1 = '0;
    case (r_state)
      S_IDLE: begin
        if (job_start) begin
          if (job_write_x)                   w_next = S_SET_X;
          else if (job_filter_bytes != 16'd0) w_next = S_LOAD_F;
          else if (job_input_bytes != 16'd0)  w_next = S_LOAD_I;
          else                                w_next = S_START;
        end
      end
      S_SET_X: begin
        if (r_fcnt != 16'd0)      w_next = S_LOAD_F;
        else if (r_icnt != 16'd0) w_next = S_LOAD_I;
        else                      w_next = S_START;
      end
      S_LOAD_F: begin
        // Leaving through a drain cycle only when no input phase follows.
        if (r_fcnt == 16'd0)                                        w_next = S_START;
        else if (w_accept && (r_fcnt == 16'd1) && (r_icnt != 16'd0)) w_next = S_LOAD_I;
      end
      S_LOAD_I:  if (r_icnt == 16'd0) w_next = S_START;
      S_START:   w_next = S_POLL;
      S_POLL:    if (r_poll_flag && cfu_ret[0]) w_next = S_FETCH;
      S_FETCH:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_OUTPUT;
      S_OUTPUT:  if (res_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase

    if (w_fire) begin
      w_cmd  = (r_state == S_LOAD_F) ? c_cmd_filter : c_cmd_input;
      w_inp0 = r_addr;
      w_inp1 = w_word;
    end else begin
      case (w_next)
        S_SET_X: begin
          w_cmd  = c_cmd_set_x;
          w_inp1 = job_start_x;
        end
        S_START: w_cmd = c_cmd_start;
        S_POLL:  w_cmd = c_cmd_poll;
        S_FETCH: w_cmd = c_cmd_result;
        default: w_cmd = NOP_CMD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fcnt      <= '0;
      r_icnt      <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_pack      <= '0;
      r_pcnt      <= '0;
      r_poll_flag <= 1'b0;
      r_cfu_en    <= 1'b0;
      r_cmd       <= NOP_CMD;
      r_inp0      <= '0;
      r_inp1      <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_cfu_en    <= (w_next != S_IDLE);
      r_cmd       <= w_cmd;
      r_inp0      <= w_inp0;
      r_inp1      <= w_inp1;
      r_res_valid <= (w_next == S_OUTPUT);
      // A poll response is trusted only if the preceding command was a poll.
      r_poll_flag <= (r_cmd == c_cmd_poll);

      if ((r_state == S_IDLE) && job_start) begin
        r_fcnt <= job_filter_bytes;
        r_icnt <= job_input_bytes;
        r_base <= job_input_base;
        r_addr <= (job_filter_bytes != 16'd0) ? '0 : job_input_base;
        r_pcnt <= '0;
      end

      if (w_accept) begin
        if (r_pcnt != 2'd3) r_pack[r_pcnt*BYTE_SIZE +: BYTE_SIZE] <= in_data;
        r_pcnt <= r_pcnt + 2'd1;
        if (r_state == S_LOAD_F) r_fcnt <= r_fcnt - 16'd1;
        else                     r_icnt <= r_icnt - 16'd1;
      end

      if (w_fire) begin
        if ((r_state == S_LOAD_F) && (w_next == S_LOAD_I)) r_addr <= r_base;
        else                                              r_addr <= r_addr + 32'd4;
      end

      if (r_state == S_CAPTURE) r_res_data <= cfu_ret;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_cfu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv1d_cfu_sequencer                                                     |
// | Scoreboard bench with a behavioural conv1d CFU model.                       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_conv1d_cfu_sequencer;

  localparam logic [6:0] NOP = 7'd19;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_start = 1'b0;
  logic [31:0] job_start_x = '0;
  logic        job_write_x = 1'b0;
  logic [15:0] job_filter_bytes = '0;
  logic [15:0] job_input_bytes = '0;
  logic [31:0] job_input_base = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        cfu_en;
  logic [6:0]  cfu_cmd;
  logic [31:0] cfu_inp0, cfu_inp1;
  logic [31:0] m_ret = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;

  conv1d_cfu_sequencer #(.INT32_SIZE(32), .BYTE_SIZE(8), .NOP_CMD(NOP)) dut (
    .clk(clk), .reset(reset), .job_start(job_start), .job_start_x(job_start_x),
    .job_write_x(job_write_x), .job_filter_bytes(job_filter_bytes),
    .job_input_bytes(job_input_bytes), .job_input_base(job_input_base), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .cfu_en(cfu_en),
    .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0), .cfu_inp1(cfu_inp1), .cfu_ret(m_ret),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  cmd;
    logic [31:0] a;
    logic [31:0] d;
    bit          ca;
    bit          cd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] res_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int res_cnt = 0;
  int n_loads = 0;
  int drop_bytes = 0;

  // CFU model state
  logic        m_done = 1'b0;
  int          m_cnt = 0;
  int          m_done_cycles = 10;
  logic [31:0] m_result = '0;
  bit          preset_req = 1'b0;
  int          acc_bytes = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endfunction

  function automatic void push_cmd(logic [6:0] c, logic [31:0] a, logic [31:0] d, bit ca, bit cd);
    exp_t e;
    e.cmd = c; e.a = a; e.d = d; e.ca = ca; e.cd = cd;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_bytes <= acc_bytes + 1;
    if (preset_req) m_ret <= 32'd1;
    if (cfu_en) begin
      if (cfu_cmd == 7'd6) begin
        m_cnt  <= m_done_cycles;
        m_done <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_done <= 1'b1;
      end
      if (cfu_cmd == 7'd9)      m_ret <= {31'b0, m_done};
      else if (cfu_cmd == 7'd7) m_ret <= m_result;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a command or a result.
  initial begin
    exp_t        e;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (cfu_cmd !== NOP) begin
        check("cmd_with_en", 32'(cfu_en), 32'd1);
        if (cfu_cmd != 7'd9) begin
          if (exp_q.size() == 0) begin
            check("cmd_unexpected", 32'(cfu_cmd), 32'(NOP));
          end else begin
            e = exp_q.pop_front();
            check("cmd", 32'(cfu_cmd), 32'(e.cmd));
            if (e.ca) check("inp0", cfu_inp0, e.a);
            if (e.cd) check("inp1", cfu_inp1, e.d);
          end
          if ((cfu_cmd == 7'd1) || (cfu_cmd == 7'd2)) begin
            check("bytes_before_cmd", 32'(acc_bytes - drop_bytes), 32'(4 * (n_loads + 1)));
            n_loads++;
          end
          if (cfu_cmd == 7'd7) check("fetch_after_done", 32'(m_done), 32'd1);
        end
      end
      if (prev_hold) begin
        check("res_valid_hold", 32'(res_valid), 32'd1);
        check("res_data_hold", res_data, prev_data);
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          check("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          r = res_q.pop_front();
          check("res_data", res_data, r);
        end
        res_cnt++;
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit wx, input logic [31:0] x, input logic [15:0] fb,
                           input logic [15:0] ib, input logic [31:0] base);
    job_write_x      = wx;
    job_start_x      = x;
    job_filter_bytes = fb;
    job_input_bytes  = ib;
    job_input_base   = base;
    job_start        = 1'b1;
    tick();
    job_start        = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] first, input bit stall);
    int i = 0;
    int guard = 0;
    bit ph = 1'b1;
    while ((i < n) && (guard < 500)) begin
      in_data  = first + 8'(i);
      in_valid = stall ? ph : 1'b1;
      ph       = ~ph;
      if (in_valid && in_ready) i++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("stream_bytes", 32'(i), 32'(n));
  endtask

  task automatic wait_result(input int target);
    int guard = 0;
    while ((res_cnt < target) && (guard < 300)) begin
      tick();
      guard++;
    end
    check("job_done", 32'(res_cnt), 32'(target));
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfu_en", 32'(cfu_en), 32'd0);
    check("rst_cfu_cmd", 32'(cfu_cmd), 32'(NOP));
    check("rst_inp0", cfu_inp0, 32'd0);
    check("rst_inp1", cfu_inp1, 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();

    // Full job, continuous stream
    m_done_cycles = 10;
    m_result      = 32'hFFFFFF85;
    push_cmd(7'd8, 32'd0, 32'd3, 1'b0, 1'b1);
    push_cmd(7'd2, 32'd0, 32'h04030201, 1'b1, 1'b1);
    push_cmd(7'd2, 32'd4, 32'h08070605, 1'b1, 1'b1);
    push_cmd(7'd1, 32'd0, 32'h0C0B0A09, 1'b1, 1'b1);
    push_cmd(7'd1, 32'd4, 32'h100F0E0D, 1'b1, 1'b1);
    push_cmd(7'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    push_cmd(7'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    res_q.push_back(32'hFFFFFF85);
    start_job(1'b1, 32'd3, 16'd8, 16'd8, 32'd0);
    check("first_cmd_latency", 32'(cfu_cmd), 32'd8);
    check("busy_after_start", 32'(busy), 32'd1);
    send_bytes(16, 8'h01, 1'b0);
    wait_result(1);

    // Filter reuse
    m_done_cycles = 4;
    m_result      = 32'h12345678;
    push_cmd(7'd1, 32'd1024, 32'hA4A3A2A1, 1'b1, 1'b1);
    push_cmd(7'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    push_cmd(7'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    res_q.push_back(32'h12345678);
    start_job(1'b0, 32'd0, 16'd0, 16'd4, 32'd1024);
    send_bytes(4, 8'hA1, 1'b0);
    wait_result(2);

    // Stream stalls
    m_done_cycles = 6;
    m_result      = 32'h00000042;
    push_cmd(7'd2, 32'd0, 32'h04030201, 1'b1, 1'b1);
    push_cmd(7'd2, 32'd4, 32'h08070605, 1'b1, 1'b1);
    push_cmd(7'd1, 32'd0, 32'h0C0B0A09, 1'b1, 1'b1);
    push_cmd(7'd1, 32'd4, 32'h100F0E0D, 1'b1, 1'b1);
    push_cmd(7'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    push_cmd(7'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    res_q.push_back(32'h00000042);
    start_job(1'b0, 32'd0, 16'd8, 16'd8, 32'd0);
    send_bytes(16, 8'h01, 1'b1);
    wait_result(3);

    // Stale ret
    preset_req = 1'b1;
    tick();
    preset_req    = 1'b0;
    m_done_cycles = 20;
    m_result      = 32'h5A5A0001;
    push_cmd(7'd2, 32'd0, 32'h24232221, 1'b1, 1'b1);
    push_cmd(7'd1, 32'd64, 32'h28272625, 1'b1, 1'b1);
    push_cmd(7'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    push_cmd(7'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    res_q.push_back(32'h5A5A0001);
    start_job(1'b0, 32'd0, 16'd4, 16'd4, 32'd64);
    send_bytes(8, 8'h21, 1'b0);
    wait_result(4);

    // Result backpressure with an ignored start
    res_ready     = 1'b0;
    m_done_cycles = 2;
    m_result      = 32'hCAFEF00D;
    push_cmd(7'd1, 32'd1024, 32'hB4B3B2B1, 1'b1, 1'b1);
    push_cmd(7'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    push_cmd(7'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    res_q.push_back(32'hCAFEF00D);
    start_job(1'b0, 32'd0, 16'd0, 16'd4, 32'd1024);
    send_bytes(4, 8'hB1, 1'b0);
    guard = 0;
    while (!res_valid && (guard < 200)) begin
      tick();
      guard++;
    end
    check("res_valid_rises", 32'(res_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        job_write_x = 1'b1;
        job_start_x = 32'd99;
        job_start   = 1'b1;
      end else begin
        job_start = 1'b0;
      end
      tick();
    end
    job_start = 1'b0;
    check("busy_in_output", 32'(busy), 32'd1);
    res_ready = 1'b1;
    tick();
    check("idle_after_ready", 32'(busy), 32'd0);
    check("res_valid_dropped", 32'(res_valid), 32'd0);
    check("bp_res_count", 32'(res_cnt), 32'd5);

    // Reset mid-LOAD_I after two bytes
    m_done_cycles = 3;
    start_job(1'b0, 32'd0, 16'd0, 16'd4, 32'd8);
    send_bytes(2, 8'hEE, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs();
    drop_bytes = 2;
    m_result   = 32'h00000007;
    push_cmd(7'd1, 32'd8, 32'h14131211, 1'b1, 1'b1);
    push_cmd(7'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    push_cmd(7'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    res_q.push_back(32'h00000007);
    start_job(1'b0, 32'd0, 16'd0, 16'd4, 32'd8);
    send_bytes(4, 8'h11, 1'b0);
    wait_result(6);

    repeat (3) tick();
    check("exp_cmds_drained", 32'(exp_q.size()), 32'd0);
    check("exp_res_drained", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
